gate_exerciser: RTL and testbench
=================================

Name: gate_exerciser

Overview:
Self-test sequencer for the basic-gate cell block (or/nand/xnor/xor/nor/and/buf/inv/notif1 sharing inputs in1, in2, Enable). On start it steps the three shared inputs through all 8 combinations. After each step it waits a programmable settle time for gate delays, samples the nine gate outputs, checks them against internally computed expected values, and reports pass/fail, the error count and the first failure. It sits between a test controller and the gate block and owns that block's inputs.

Parameters:
SETTLE, 4, clock cycles each vector is held before sampling (must be >=1).
CW, 4, width of the settle counter (2**CW > SETTLE).

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin a run; accepted only in IDLE or DONE
abort  input  1  cancel a run in progress
obs  input  9  gate outputs: [0]outOr [1]outNand [2]outXnor [3]outXor [4]outNor [5]outAnd [6]outBuf [7]outInv [8]outNotIf1
in1  output  1  drive to gate block
in2  output  1  drive to gate block
Enable  output  1  drive to gate block (notif1 enable)
busy  output  1  run in progress
done  output  1  run complete; holds until next start, abort or reset
pass  output  1  valid when done: 1 if err_count==0
err_count  output  4  number of failing vectors (0..8)
fail_vec  output  3  index of first failing vector
fail_mask  output  9  mismatching obs bits of first failing vector

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; vec=0; cnt=0; first-fail flag cleared.
- Vector index vec[2:0]: in2=vec[0], in1=vec[1], Enable=vec[2]. Outputs are registered from vec, so they change on the clock edge that enters SETTLE.
- Expected from a=in1, b=in2: or=a|b, nand=~(a&b), xnor=~(a^b), xor=a^b, nor=~(a|b), and=a&b, buf=a, inv=~a, notif1=~a.
- Bit 8 is masked (don't-care) when Enable=0, because notif1 floats then.
- The comparison must not depend on X/Z values in masked bits.
- FSM states:
  - IDLE: in1=in2=Enable=0, busy=0. start=1 -> SETTLE; vec=0, cnt=0, busy=1, done=0, err_count=0, fail_vec=0, fail_mask=0, first-fail flag cleared.
  - SETTLE: drives vec; cnt++ each cycle; when cnt==SETTLE-1 -> CHECK.
  - CHECK (1 cycle): mism = (obs ^ expected) & mask.
    - If mism!=0: err_count++.
    - If mism!=0 and no earlier failure: capture fail_vec=vec, fail_mask=mism, set first-fail flag.
    - Then, if vec==7 -> DONE; else vec++, cnt=0 -> SETTLE.
  - DONE: busy=0, done=1, pass=(err_count==0); in1/in2/Enable hold the last vector. start=1 -> same as start in IDLE (results cleared, re-run).
- Latency: vector n is sampled SETTLE cycles after it is applied. done rises 8*(SETTLE+1) cycles after the start-accept edge.
- start while busy: ignored.
- abort in SETTLE/CHECK: next edge -> IDLE; busy=0, done=0, pass=0, outputs 0; partial err_count/fail_* are retained.
- abort has priority over a CHECK in the same cycle (that sample is discarded).
- abort in IDLE/DONE: no effect.
- start and abort asserted together: abort wins.
- rst mid-run: immediate return to reset values; no partial results.
- err_count never exceeds 8, so it needs no saturation.

Test Plan:
1. Ideal gate model, SETTLE=4: pulse start -> busy for 40 cycles, then done=1, pass=1, err_count=0; in1/in2/Enable step through 000..111 with 5 cycles per vector.
2. outAnd stuck-at-0 -> err_count=2 (vectors 3 and 7), fail_vec=3, fail_mask=9'h020, pass=0.
3. outNotIf1 driven Z for Enable=0 and correct for Enable=1 -> pass=1. Then invert it for Enable=1 -> err_count=4, fail_vec=4, fail_mask=9'h100.
4. abort asserted in SETTLE of vector 5 -> next edge IDLE, outputs 0, done=0. A following start re-runs from vector 0 and completes with correct results.
5. rst pulsed mid-CHECK, off-clock-edge -> all outputs 0 immediately. After release, start behaves as a fresh run.
6. start held high for the entire run -> exactly one run; at the DONE edge start is accepted again, results are cleared and a second run of 40 cycles follows.

Source files
------------

// File: rtl/gate_exerciser.sv
// gate_exerciser: self-test sequencer for the basic-gate cell block.
// It steps in1/in2/Enable through all 8 vectors, waits a settle time, then checks the nine gate outputs.
`default_nettype none

module gate_exerciser #(
  parameter int SETTLE = 4,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [8:0] obs,
  output logic       in1,
  output logic       in2,
  output logic       Enable,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec,
  output logic [8:0] fail_mask
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t        state;
  logic [2:0]    vec;
  logic [CW-1:0] cnt;
  logic          first_fail;

  logic [8:0] expected;
  logic [8:0] mask;
  logic [8:0] mism;
  logic [3:0] err_next;
  logic [2:0] vec_next;

  // Expected values come from the registered drives, which always equal vec while SETTLE/CHECK.
  always_comb begin
    expected = {~in1, ~in1, in1, in1 & in2, ~(in1 | in2), in1 ^ in2,
                ~(in1 ^ in2), ~(in1 & in2), in1 | in2};
    // notif1 floats while disabled; masking after the XOR forces those bits to 0 even if obs is X/Z.
    mask     = {Enable, 8'hFF};
    mism     = (obs ^ expected) & mask;
    err_next = err_count + {3'b000, |mism};
    vec_next = vec + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vec        <= 3'd0;
      cnt        <= '0;
      first_fail <= 1'b0;
      in1        <= 1'b0;
      in2        <= 1'b0;
      Enable     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 4'd0;
      fail_vec   <= 3'd0;
      fail_mask  <= 9'd0;
    end else if (abort && (state == S_SETTLE || state == S_CHECK)) begin
      // Partial results stay visible for debug after an abort.
      state  <= S_IDLE;
      in1    <= 1'b0;
      in2    <= 1'b0;
      Enable <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            state      <= S_SETTLE;
            vec        <= 3'd0;
            cnt        <= '0;
            first_fail <= 1'b0;
            in1        <= 1'b0;
            in2        <= 1'b0;
            Enable     <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 4'd0;
            fail_vec   <= 3'd0;
            fail_mask  <= 9'd0;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(SETTLE - 1)) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_count <= err_next;
          if ((|mism) && !first_fail) begin
            first_fail <= 1'b1;
            fail_vec   <= vec;
            fail_mask  <= mism;
          end
          if (vec == 3'd7) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 4'd0);
          end else begin
            state                <= S_SETTLE;
            vec                  <= vec_next;
            cnt                  <= '0;
            {Enable, in1, in2}   <= vec_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: directed bench for gate_exerciser with a behavioural gate block and fault injection.
`default_nettype none

module tb_gate_exerciser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [8:0] obs;
  logic       in1, in2, Enable, busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_vec;
  logic [8:0] fail_mask;

  int checks = 0;
  int errors = 0;
  int fault  = 0;  // 0 ideal, 1 and stuck-at-0, 2 notif1 Z when disabled, 3 as 2 plus notif1 inverted when enabled
  logic [4:0] sb[$];  // {busy, done, vector}

  gate_exerciser #(.SETTLE(4), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .obs(obs),
    .in1(in1), .in2(in2), .Enable(Enable), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec), .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  // Behavioural gate block
  always_comb begin
    obs[0] = in1 | in2;
    obs[1] = !(in1 && in2);
    obs[2] = (in1 == in2);
    obs[3] = (in1 != in2);
    obs[4] = !(in1 || in2);
    obs[5] = (fault == 1) ? 1'b0 : (in1 && in2);
    obs[6] = in1;
    obs[7] = !in1;
    if (!Enable)
      obs[8] = (fault >= 2) ? 1'bz : 1'b0;
    else
      obs[8] = (fault == 3) ? in1 : !in1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_results(input logic [3:0] e_err, input logic [2:0] e_fv,
                               input logic [8:0] e_fm, input logic e_pass);
    check("err_count", err_count, e_err);
    check("fail_vec", fail_vec, e_fv);
    check("fail_mask", fail_mask, e_fm);
    check("pass", pass, e_pass);
  endtask

  task automatic check_idle();
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_pass", pass, 1'b0);
    check("idle_drive", {Enable, in1, in2}, 3'd0);
  endtask

  // Called at a negedge; returns at the negedge after the start-accept edge.
  task automatic start_run(input bit hold);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Cycle k counts negedges after the start-accept edge; each vector spans 5 cycles.
  task automatic expect_cycles(input int k_from, input int k_to);
    logic [4:0] e;
    for (int k = k_from; k <= k_to; k++)
      sb.push_back((k < 40) ? {2'b10, 3'(k / 5)} : 5'b01111);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("busy", busy, e[4]);
      check("done", done, e[3]);
      check("drive", {Enable, in1, in2}, e[2:0]);
      if (sb.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle();
    check_results(4'd0, 3'd0, 9'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Ideal gates
    fault = 0;
    start_run(1'b0);
    expect_cycles(0, 40);
    check_results(4'd0, 3'd0, 9'd0, 1'b1);

    // outAnd stuck-at-0
    fault = 1;
    @(negedge clk);
    start_run(1'b0);
    expect_cycles(0, 40);
    check_results(4'd2, 3'd3, 9'h020, 1'b0);

    // notif1 floats when disabled, correct otherwise
    fault = 2;
    @(negedge clk);
    start_run(1'b0);
    expect_cycles(0, 40);
    check_results(4'd0, 3'd0, 9'd0, 1'b1);

    // notif1 inverted when enabled
    fault = 3;
    @(negedge clk);
    start_run(1'b0);
    expect_cycles(0, 40);
    check_results(4'd4, 3'd4, 9'h100, 1'b0);

    // abort in SETTLE of vector 5, partial results retained
    fault = 1;
    @(negedge clk);
    start_run(1'b0);
    expect_cycles(0, 26);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle();
    check("abort_err", err_count, 4'd1);
    check("abort_fvec", fail_vec, 3'd3);
    check("abort_fmask", fail_mask, 9'h020);
    repeat (3) @(negedge clk);
    check_idle();
    fault = 0;
    start_run(1'b0);
    expect_cycles(0, 40);
    check_results(4'd0, 3'd0, 9'd0, 1'b1);

    // asynchronous reset during CHECK of vector 4
    fault = 1;
    @(negedge clk);
    start_run(1'b0);
    expect_cycles(0, 24);
    check("pre_rst_err", err_count, 4'd1);
    rst = 1'b1;
    #1;
    check_idle();
    check_results(4'd0, 3'd0, 9'd0, 1'b0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle();
    fault = 0;
    start_run(1'b0);
    expect_cycles(0, 40);
    check_results(4'd0, 3'd0, 9'd0, 1'b1);

    // start held high: one run, then re-accepted at DONE with cleared results
    fault = 1;
    @(negedge clk);
    start_run(1'b1);
    expect_cycles(0, 40);
    check_results(4'd2, 3'd3, 9'h020, 1'b0);
    fault = 0;
    start_run(1'b0);
    expect_cycles(0, 40);
    check_results(4'd0, 3'd0, 9'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
